button_conditioner: RTL and testbench

- Parametrised, multi-channel successor to the single-bit edge detector used on the DE0-Nano pushbuttons and switches.
- Runs entirely on the system clock; a clock-enable tick replaces the divided clock.
- Per channel: synchronises the raw input, optionally inverts it, debounces it, and reports the clean level plus one-cycle rise and fall pulses.
- Sits between the board pins (KEY/SW) and any control logic in the top level.

---
 rtl/button_conditioner_pkg.sv | 17 +
 rtl/button_conditioner_if.sv | 19 +
 rtl/debounce_channel.sv | 63 ++++++
 rtl/button_conditioner.sv | 57 +++++
 tb/tb_button_conditioner.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared defaults for the pushbutton/switch conditioner.
// SIMULATE shortens the prescaler so a debounce takes a few dozen clocks
// instead of a few million, keeping simulations short.
package button_conditioner_pkg;

  localparam int DEF_CHANNELS = 2;
`ifdef SIMULATE
  localparam int DEF_PRESCALE_BITS = 2;
  localparam int DEF_STABLE_TICKS  = 3;
`else
  // 2^16 clocks at 50 MHz is ~1.3 ms per tick; 4 ticks ~5 ms of stability.
  localparam int DEF_PRESCALE_BITS = 16;
  localparam int DEF_STABLE_TICKS  = 4;
`endif
  localparam int DEF_CNT_W = 3;

endpackage

// File: rtl/button_conditioner_if.sv
// Pin-side bundle of the conditioner.
//   IN    : raw asynchronous pin levels (driven by the board / bench)
//   LEVEL : debounced active-high level per channel
//   RISE  : one-cycle pulse when LEVEL goes 0->1
//   FALL  : one-cycle pulse when LEVEL goes 1->0
//   TICK  : prescaler strobe, shared with other slow logic
// master = pin/consumer side, slave = the conditioner itself.
interface button_conditioner_if #(
  parameter int CHANNELS = 2
);
  logic [CHANNELS-1:0] IN;
  logic [CHANNELS-1:0] LEVEL;
  logic [CHANNELS-1:0] RISE;
  logic [CHANNELS-1:0] FALL;
  logic                TICK;

  modport master (output IN, input LEVEL, RISE, FALL, TICK);
  modport slave  (input IN, output LEVEL, RISE, FALL, TICK);
endinterface

// File: rtl/debounce_channel.sv
// One conditioned input: 2-FF synchroniser, optional inversion, tick-based
// debounce counter, registered LEVEL and one-cycle RISE/FALL pulses.
// Ports: CLK, RST_N (async low), TICK (prescaler strobe), IN (raw pin),
//        LEVEL, RISE, FALL.
module debounce_channel #(
  parameter int   STABLE_TICKS = 4,
  parameter int   CNT_W        = 3,
  parameter logic INVERT       = 1'b1
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic TICK,
  input  logic IN,
  output logic LEVEL,
  output logic RISE,
  output logic FALL
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_TICKS - 1);

  logic             sync1, sync2;
  logic             s;
  logic [CNT_W-1:0] cnt;

  // Synchroniser resets to the idle pin level so the post-invert value
  // starts at 0 and matches LEVEL: no spurious debounce after reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1 <= INVERT;
      sync2 <= INVERT;
    end else begin
      sync1 <= IN;
      sync2 <= sync1;
    end
  end

  assign s = sync2 ^ INVERT;

  // cnt counts ticks during which s has disagreed with LEVEL without a
  // break; any cycle of agreement throws the partial count away.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt   <= '0;
      LEVEL <= 1'b0;
      RISE  <= 1'b0;
      FALL  <= 1'b0;
    end else begin
      RISE <= 1'b0;
      FALL <= 1'b0;
      if (s == LEVEL) begin
        cnt <= '0;
      end else if (TICK && cnt == LAST) begin
        LEVEL <= s;
        cnt   <= '0;
        RISE  <= s;
        FALL  <= ~s;
      end else if (TICK) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel pushbutton/switch conditioner on the system clock.
// A free-running prescaler produces TICK (one cycle every 2^PRESCALE_BITS
// clocks); each channel debounces its pin against that tick.
// Ports: CLK (CLOCK_50), RST_N (async low), bus (slave side of
//        button_conditioner_if: IN in; LEVEL/RISE/FALL/TICK out).
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int                  CHANNELS      = DEF_CHANNELS,
  parameter int                  PRESCALE_BITS = DEF_PRESCALE_BITS,
  parameter int                  STABLE_TICKS  = DEF_STABLE_TICKS,
  parameter int                  CNT_W         = DEF_CNT_W,
  parameter logic [CHANNELS-1:0] INVERT        = '1
) (
  input  logic              CLK,
  input  logic              RST_N,
  button_conditioner_if.slave bus
);

  logic [PRESCALE_BITS-1:0] pre;
  logic                     tick_q;
  logic [CHANNELS-1:0]      level_w, rise_w, fall_w;

  // TICK is registered off the all-ones count, so the first strobe lands
  // 2^PRESCALE_BITS clocks after reset release; the counter wraps freely.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pre    <= '0;
      tick_q <= 1'b0;
    end else begin
      pre    <= pre + 1'b1;
      tick_q <= &pre;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS (STABLE_TICKS),
      .CNT_W        (CNT_W),
      .INVERT       (INVERT[i])
    ) u_ch (
      .CLK   (CLK),
      .RST_N (RST_N),
      .TICK  (tick_q),
      .IN    (bus.IN[i]),
      .LEVEL (level_w[i]),
      .RISE  (rise_w[i]),
      .FALL  (fall_w[i])
    );
  end

  assign bus.TICK  = tick_q;
  assign bus.LEVEL = level_w;
  assign bus.RISE  = rise_w;
  assign bus.FALL  = fall_w;

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

  localparam int ST = 3;   // STABLE_TICKS
  localparam int TP = 4;   // tick period = 2^PRESCALE_BITS

  logic CLK = 1'b0;
  logic RST_N = 1'b1;
  logic clk_en = 1'b0;

  button_conditioner_if #(.CHANNELS(2)) bus ();

  button_conditioner #(
    .CHANNELS(2), .PRESCALE_BITS(2), .STABLE_TICKS(ST), .CNT_W(3), .INVERT(2'b11)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial forever begin
    #5;
    if (clk_en) CLK = ~CLK;
  end

  int n_vec = 0, n_err = 0;

  // ---- reference model: pins -> active-high samples delayed 2 clocks;
  // LEVEL follows s once ST ticks in a row have seen disagreement.
  logic [1:0] m_p1, m_p2, m_level, m_rise, m_fall;
  int         m_run[2];
  logic       m_tick;
  int         m_edges;

  task automatic model_reset();
    m_p1 = '0; m_p2 = '0; m_level = '0; m_rise = '0; m_fall = '0;
    m_run[0] = 0; m_run[1] = 0; m_tick = 1'b0; m_edges = 0;
  endtask

  task automatic model_edge(input logic [1:0] pin);
    logic [1:0] s_old;
    logic       t_old;
    s_old = m_p2;
    t_old = m_tick;
    for (int c = 0; c < 2; c++) begin
      m_rise[c] = 1'b0;
      m_fall[c] = 1'b0;
      if (s_old[c] == m_level[c]) m_run[c] = 0;
      else if (t_old) begin
        m_run[c]++;
        if (m_run[c] == ST) begin
          m_level[c] = s_old[c];
          m_rise[c]  = s_old[c];
          m_fall[c]  = !s_old[c];
          m_run[c]   = 0;
        end
      end
    end
    m_p2 = m_p1;
    m_p1 = ~pin;
    m_edges++;
    m_tick = (m_edges % TP == 0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-channel pulse counters seen on the DUT.
  int obs_r[2], obs_f[2];
  task automatic clr_obs();
    obs_r[0] = 0; obs_r[1] = 0; obs_f[0] = 0; obs_f[1] = 0;
  endtask

  // One clock: drive pin, advance model on the edge, compare at negedge.
  task automatic step(input logic [1:0] pin);
    bus.IN = pin;
    @(posedge CLK);
    model_edge(pin);
    @(negedge CLK);
    chk("model", {25'd0, bus.LEVEL, bus.RISE, bus.FALL, bus.TICK},
        {25'd0, m_level, m_rise, m_fall, m_tick});
    for (int c = 0; c < 2; c++) begin
      if (bus.RISE[c]) obs_r[c]++;
      if (bus.FALL[c]) obs_f[c]++;
    end
  endtask

  typedef struct {
    logic [1:0] pin;
    int         cyc;
    logic [1:0] lvl;
    int         r0, r1, f0, f1;
  } vec_t;
  vec_t tbl[7];

  initial begin
    int n;
    bit seen;
    // ---- 1. reset with clock stopped: outputs clear immediately
    bus.IN = 2'b11;
    #2 RST_N = 1'b0;
    #3 chk("reset_async", {28'd0, bus.LEVEL, bus.TICK, bus.RISE[0], bus.FALL[0]}, 32'd0);
    chk("reset_pulses", {30'd0, bus.RISE | bus.FALL}, 32'd0);
    model_reset();
    RST_N = 1'b1;
    clk_en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step(2'b11);
      chk($sformatf("tick_edge%0d", k), {31'd0, bus.TICK}, {31'd0, (k % 4 == 0)});
    end

    // ---- table: hold a pin pattern, then check level and pulse counts
    tbl[0] = '{2'b11, 20, 2'b00, 0, 0, 0, 0};
    tbl[1] = '{2'b10, 20, 2'b01, 1, 0, 0, 0};
    tbl[2] = '{2'b11, 20, 2'b00, 0, 0, 1, 0};
    tbl[3] = '{2'b00, 20, 2'b11, 1, 1, 0, 0};
    tbl[4] = '{2'b11, 20, 2'b00, 0, 0, 1, 1};
    tbl[5] = '{2'b01, 20, 2'b10, 0, 1, 0, 0};
    tbl[6] = '{2'b11, 20, 2'b00, 0, 0, 0, 1};
    for (int v = 0; v < 7; v++) begin
      clr_obs();
      repeat (tbl[v].cyc) step(tbl[v].pin);
      chk($sformatf("tbl%0d_level", v), {30'd0, bus.LEVEL}, {30'd0, tbl[v].lvl});
      chk($sformatf("tbl%0d_counts", v), {obs_r[0][7:0], obs_r[1][7:0], obs_f[0][7:0], obs_f[1][7:0]},
          {tbl[v].r0[7:0], tbl[v].r1[7:0], tbl[v].f0[7:0], tbl[v].f1[7:0]});
    end

    // ---- 2. clean press latency, RISE in the same cycle LEVEL shows 1
    clr_obs();
    n = 0; seen = 0;
    while (!seen && n < 30) begin
      step(2'b10);
      n++;
      if (bus.LEVEL[0]) begin
        seen = 1;
        chk("press_rise_same_cycle", {31'd0, bus.RISE[0]}, 32'd1);
        chk("press_ch1_quiet", {30'd0, bus.LEVEL[1], bus.RISE[1]}, 32'd0);
      end
    end
    chk("press_latency_ok", {31'd0, (seen && n >= 9 && n <= 15)}, 32'd1);
    repeat (5) step(2'b10);
    chk("press_one_rise", obs_r[0], 1);

    // ---- 4. release: single FALL
    clr_obs();
    repeat (20) step(2'b11);
    chk("release_level", {31'd0, bus.LEVEL[0]}, 32'd0);
    chk("release_one_fall", {obs_f[0][15:0], obs_r[0][15:0]}, {16'd1, 16'd0});

    // ---- 3. bounce: toggles every 5 clocks never survive 3 ticks
    clr_obs();
    for (int b = 0; b < 8; b++) repeat (5) step((b % 2 == 0) ? 2'b10 : 2'b11);
    chk("bounce_quiet", {bus.LEVEL[0], obs_r[0][14:0], obs_f[0][15:0]}, 32'd0);
    repeat (20) step(2'b10);
    chk("bounce_settle", {bus.LEVEL[0], obs_r[0][14:0], obs_f[0][15:0]}, {1'b1, 15'd1, 16'd0});
    repeat (20) step(2'b11);

    // ---- 5. simultaneous press: both RISE in one cycle
    n = 0; seen = 0;
    while (!seen && n < 30) begin
      step(2'b00);
      n++;
      if (bus.RISE != 2'b00) begin
        seen = 1;
        chk("simul_rise", {30'd0, bus.RISE}, 32'd3);
      end
    end
    chk("simul_seen", {31'd0, seen}, 32'd1);
    repeat (5) step(2'b00);
    chk("simul_level", {30'd0, bus.LEVEL}, 32'd3);
    repeat (20) step(2'b11);

    // ---- 6. reset mid-debounce
    n = 0;
    for (int k = 0; k < 20 && n < 2; k++) begin
      step(2'b10);
      if (bus.TICK) n++;
    end
    chk("mid_two_ticks", n, 2);
    #2 RST_N = 1'b0;
    #1 chk("mid_reset_clear", {27'd0, bus.LEVEL, bus.RISE[0], bus.FALL[0], bus.TICK}, 32'd0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    model_reset();
    clr_obs();
    repeat (25) step(2'b10);
    chk("mid_after", {bus.LEVEL[0], obs_r[0][14:0], obs_f[0][15:0]}, {1'b1, 15'd1, 16'd0});
    repeat (20) step(2'b11);

    // ---- randomized soak against the model
    for (int r = 0; r < 150; r++) begin
      logic [1:0] p;
      int h;
      p = 2'($urandom_range(0, 3));
      h = $urandom_range(1, 24);
      repeat (h) step(p);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
